// File: rtl/hazard_unit_p.sv
// Hazard unit: E/M/W operand forwarding, load-use stall, mul/div busy tracking, flush control.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_unit_p #(
  parameter int RW       = 5,
  parameter int LD_STALL = 1,
  parameter int MD_LAT   = 4,
  parameter int PCW      = 32
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic [RW-1:0]  rs,
  input  logic [RW-1:0]  rt,
  input  logic           users,
  input  logic           usert,
  input  logic [RW-1:0]  erd,
  input  logic [RW-1:0]  mrd,
  input  logic [RW-1:0]  wrd,
  input  logic           ewreg,
  input  logic           mwreg,
  input  logic           wwreg,
  input  logic           eload,
  input  logic           mdstart,
  input  logic [RW-1:0]  mdrd,
  input  logic           brtaken,
  input  logic           jump,
  output logic [1:0]     fwda,
  output logic [1:0]     fwdb,
  output logic           stallf,
  output logic           stalld,
  output logic           bubblee,
  output logic           flushd,
  output logic           mdbusy,
  output logic           mddone,
  output logic [PCW-1:0] stallcnt,
  output logic [PCW-1:0] flushcnt
);

  localparam int LCW = (LD_STALL > 1) ? $clog2(LD_STALL) : 1;
  localparam int MCW = $clog2(MD_LAT);

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [LCW-1:0] ld_cnt_reg, ld_cnt_next;
  logic [0:0]     md_state_reg, md_state_next;
  logic [MCW-1:0] md_cnt_reg, md_cnt_next;
  logic [RW-1:0]  md_rd_reg, md_rd_next;

  logic [RW-1:0] src [2];
  logic [1:0]    src_use;
  logic [3:0]    fwd_vec;
  logic [1:0]    ld_src_hit;
  logic [1:0]    md_src_hit;

  logic ld_haz;
  logic md_haz;
  logic stall;
  logic md_accept;
  logic md_busy_st;
  logic md_last;

  assign src[0]  = rs;
  assign src[1]  = rt;
  assign src_use = {usert, users};

  // One forwarding mux per source operand; index 0 is rs, index 1 is rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic       e_hit;
      logic       m_hit;
      logic       w_hit;
      logic [1:0] sel;

      assign e_hit = src_use[gi] & ewreg & (erd == src[gi]) & (erd != '0);
      assign m_hit = src_use[gi] & mwreg & (mrd == src[gi]) & (mrd != '0);
      assign w_hit = src_use[gi] & wwreg & (wrd == src[gi]) & (wrd != '0);

      // A load in E has no data yet; stall covers it, and older stages must not win.
      always_comb begin
        sel = 2'b00;
        if (e_hit) begin
          sel = eload ? 2'b00 : 2'b10;
        end else if (m_hit) begin
          sel = 2'b01;
        end else if (w_hit) begin
          sel = 2'b11;
        end
      end

      assign fwd_vec[gi*2 +: 2] = sel;
      assign ld_src_hit[gi]     = src_use[gi] & (src[gi] == erd);
      assign md_src_hit[gi]     = src_use[gi] & (src[gi] == md_rd_reg);
    end
  endgenerate

  assign fwda = fwd_vec[1:0];
  assign fwdb = fwd_vec[3:2];

  assign md_busy_st = (md_state_reg == MD_BUSY);
  assign md_last    = md_busy_st & (md_cnt_reg == '0);

  assign ld_haz = ewreg & eload & (erd != '0) & (|ld_src_hit);
  // Held through the done cycle; the result then arrives via W forwarding.
  assign md_haz = md_busy_st & (mdstart | ((md_rd_reg != '0) & (|md_src_hit)));
  assign stall  = ld_haz | (ld_cnt_reg != '0) | md_haz;

  assign md_accept = (md_state_reg == MD_IDLE) & mdstart & ~stall & ~brtaken;

  always_comb begin
    ld_cnt_next = ld_cnt_reg;
    if (brtaken) begin
      ld_cnt_next = '0;
    end else if (ld_cnt_reg != '0) begin
      ld_cnt_next = ld_cnt_reg - LCW'(1);
    end else if (ld_haz) begin
      ld_cnt_next = LCW'(LD_STALL - 1);
    end
  end

  // An in-flight mul/div op is older than any branch, so brtaken never cancels it.
  always_comb begin
    md_state_next = md_state_reg;
    md_cnt_next   = md_cnt_reg;
    md_rd_next    = md_rd_reg;
    case (md_state_reg)
      MD_IDLE: begin
        if (md_accept) begin
          md_state_next = MD_BUSY;
          md_cnt_next   = MCW'(MD_LAT - 1);
          md_rd_next    = mdrd;
        end
      end
      default: begin
        if (md_cnt_reg == '0) begin
          md_state_next = MD_IDLE;
        end else begin
          md_cnt_next = md_cnt_reg - MCW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ld_cnt_reg   <= '0;
      md_state_reg <= MD_IDLE;
      md_cnt_reg   <= '0;
      md_rd_reg    <= '0;
    end else begin
      ld_cnt_reg   <= ld_cnt_next;
      md_state_reg <= md_state_next;
      md_cnt_reg   <= md_cnt_next;
      md_rd_reg    <= md_rd_next;
    end
  end

  // Control outputs are forced low while reset is held.
  assign stallf  = clrn & stall & ~brtaken;
  assign stalld  = clrn & stall & ~brtaken;
  assign bubblee = clrn & (stall | brtaken);
  assign flushd  = clrn & (brtaken | (jump & ~stall));
  assign mdbusy  = clrn & md_busy_st;
  assign mddone  = clrn & md_last;

`ifdef HAZ_PERF_EN
  logic [PCW-1:0] stall_cnt_reg;
  logic [PCW-1:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stallf) begin
        stall_cnt_reg <= stall_cnt_reg + PCW'(1);
      end
      if (flushd) begin
        flush_cnt_reg <= flush_cnt_reg + PCW'(1);
      end
    end
  end

  assign stallcnt = stall_cnt_reg;
  assign flushcnt = flush_cnt_reg;
`else
  assign stallcnt = '0;
  assign flushcnt = '0;
`endif

endmodule
